// File: rtl/pulse_period_checker_pkg.sv
// -----------------------------------------------------------------------------
// pulse_period_checker_pkg
// Shared definitions for the pulse period checker:
//   - state_e        : FSM state encoding (SEARCH / TRACK / LOCKED)
//   - *_DEF          : default PERIOD, LOCK_COUNT and CNT_W parameter values
//   - ERR_W          : width of the saturating error counter
//   - err_count_next : next value of the saturating error counter
// -----------------------------------------------------------------------------
package pulse_period_checker_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int PERIOD_DEF     = 129;
    localparam int LOCK_COUNT_DEF = 4;
    localparam int CNT_W_DEF      = 8;
    localparam int ERR_W          = 8;

    // A clear wins over the held count, but an error in the clearing cycle
    // still counts as the first error of the fresh window.
    function automatic logic [ERR_W-1:0] err_count_next(
        input logic [ERR_W-1:0] cur,
        input logic             err,
        input logic             clr
    );
        logic [ERR_W-1:0] nxt;
        if (clr) begin
            nxt = err ? 8'h01 : 8'h00;
        end else if (err && (cur != 8'hFF)) begin
            nxt = cur + 8'h01;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pulse_period_checker_interval_counter.sv
// -----------------------------------------------------------------------------
// pulse_period_checker_interval_counter
// Counts ce-qualified cycles since the last pulse event and presents the
// interval that would be measured if an event arrived now.
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous active-high reset
//   ce_i     in   clock enable; counting only advances on ce cycles
//   restart  in   pulse event; clears the count
//   m        out  measured interval cnt+1, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module pulse_period_checker_interval_counter
    import pulse_period_checker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ce_i,
    input  logic             restart,
    output logic [CNT_W-1:0] m
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Interval count: restart on an event, otherwise saturating ce count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (restart) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ce_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign m = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_W'(1));

endmodule

// File: rtl/pulse_period_checker.sv
// -----------------------------------------------------------------------------
// pulse_period_checker
// Watches a periodic one-ce-wide tick stream, measures pulse spacing in
// ce-qualified cycles and reports lock, missing pulses and early pulses.
// Optional feature macro: PULSE_CHECK_ERRCNT_EN builds the saturating error
// counter and its clear; without it err_count_o is tied to zero.
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous active-high reset
//   ce_i         in   clock enable; pulse_i sampled only when high
//   pulse_i      in   tick input
//   clear_err_i  in   synchronous clear of err_count_o
//   locked_o     out  high while locked
//   miss_o       out  one-cycle flag: expected pulse absent
//   early_o      out  one-cycle flag: pulse arrived before PERIOD
//   period_o     out  last measured interval (saturating)
//   err_count_o  out  saturating count of miss and early events
// -----------------------------------------------------------------------------
module pulse_period_checker
    import pulse_period_checker_pkg::*;
#(
    parameter int PERIOD     = PERIOD_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ce_i,
    input  logic             pulse_i,
    input  logic             clear_err_i,
    output logic             locked_o,
    output logic             miss_o,
    output logic             early_o,
    output logic [CNT_W-1:0] period_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam logic [CNT_W-1:0] PERIOD_C     = CNT_W'(PERIOD);
    localparam logic [3:0]       LOCK_COUNT_C = 4'(LOCK_COUNT);

    state_e           state_r;
    state_e           state_next_s;
    logic [3:0]       good_r;
    logic [3:0]       good_next_s;
    logic             event_s;
    logic             miss_s;
    logic             early_s;
    logic             upd_period_s;
    logic [CNT_W-1:0] m_s;

    assign event_s = ce_i & pulse_i;

    pulse_period_checker_interval_counter #(
        .CNT_W (CNT_W)
    ) interval_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ce_i    (ce_i),
        .restart (event_s),
        .m       (m_s)
    );

    // Next-state, good-interval count and event flags.
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_r;
        miss_s       = 1'b0;
        early_s      = 1'b0;
        upd_period_s = 1'b0;
        case (state_r)
            SEARCH: begin
                // First pulse only establishes the reference point.
                if (event_s) begin
                    state_next_s = TRACK;
                    good_next_s  = 4'd0;
                end else begin
                    state_next_s = SEARCH;
                end
            end
            TRACK, LOCKED: begin
                if (event_s) begin
                    upd_period_s = 1'b1;
                    if (m_s == PERIOD_C) begin
                        if (state_r == LOCKED) begin
                            state_next_s = LOCKED;
                        end else if ((good_r + 4'd1) >= LOCK_COUNT_C) begin
                            state_next_s = LOCKED;
                            good_next_s  = good_r + 4'd1;
                        end else begin
                            good_next_s  = good_r + 4'd1;
                        end
                    end else if (m_s < PERIOD_C) begin
                        early_s      = 1'b1;
                        state_next_s = TRACK;
                        good_next_s  = 4'd0;
                    end else begin
                        // Longer than PERIOD cannot occur here because the
                        // miss below fires first; restart tracking if it does.
                        state_next_s = TRACK;
                        good_next_s  = 4'd0;
                    end
                end else if (ce_i && (m_s == PERIOD_C)) begin
                    // Dropping to SEARCH guarantees a single miss per gap.
                    miss_s       = 1'b1;
                    state_next_s = SEARCH;
                    good_next_s  = 4'd0;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = SEARCH;
                good_next_s  = 4'd0;
            end
        endcase
    end

    // State, good counter and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= SEARCH;
            good_r   <= 4'd0;
            locked_o <= 1'b0;
            miss_o   <= 1'b0;
            early_o  <= 1'b0;
            period_o <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            good_r   <= good_next_s;
            locked_o <= (state_next_s == LOCKED);
            miss_o   <= miss_s;
            early_o  <= early_s;
            period_o <= upd_period_s ? m_s : period_o;
        end
    end

`ifdef PULSE_CHECK_ERRCNT_EN
    // Saturating error counter with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_count_o <= 8'h00;
        end else begin
            err_count_o <= err_count_next(err_count_o, miss_s | early_s, clear_err_i);
        end
    end
`else
    logic unused_clear_err_s;
    assign unused_clear_err_s = clear_err_i;
    assign err_count_o        = 8'h00;
`endif

endmodule

// File: tb/tb_pulse_period_checker.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_checker
// Directed self-checking bench for pulse_period_checker with default
// parameters. Expected error counts follow PULSE_CHECK_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_pulse_period_checker;

`ifdef PULSE_CHECK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       ce_i = 1'b0;
    logic       pulse_i = 1'b0;
    logic       clear_err_i = 1'b0;
    logic       locked_o;
    logic       miss_o;
    logic       early_o;
    logic [7:0] period_o;
    logic [7:0] err_count_o;

    int checks = 0;
    int errors = 0;
    int miss_seen = 0;
    int early_seen = 0;

    pulse_period_checker dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ce_i        (ce_i),
        .pulse_i     (pulse_i),
        .clear_err_i (clear_err_i),
        .locked_o    (locked_o),
        .miss_o      (miss_o),
        .early_o     (early_o),
        .period_o    (period_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_err(input int v);
        return ERR_EN ? 32'(v) : 32'd0;
    endfunction

    // One clock: drive inputs, then sample outputs 1 time unit after the edge.
    task automatic cyc(input logic ce, input logic p);
        ce_i    = ce;
        pulse_i = p;
        @(posedge clk_i);
        #1;
        if (miss_o)  miss_seen++;
        if (early_o) early_seen++;
    endtask

    task automatic gap_pulse();
        repeat (128) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc(1'b0, 1'b0);
        reset_i = 1'b0;
        miss_seen  = 0;
        early_seen = 0;
    endtask

    // Sparse-enable period: 387 clocks, ce every 3rd, pulse held 3 clocks.
    task automatic sparse_period(input logic with_pulse);
        for (int k = 0; k < 387; k++) begin
            cyc((k % 3) == 0, with_pulse && (k < 3));
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_miss",   32'(miss_o), 32'd0);
        check("rst_early",  32'(early_o), 32'd0);
        check("rst_period", 32'(period_o), 32'd0);
        check("rst_err",    32'(err_count_o), 32'd0);

        // Lock from reset
        cyc(1'b1, 1'b1);
        check("first_no_period", 32'(period_o), 32'd0);
        repeat (3) gap_pulse();
        check("pre_lock", 32'(locked_o), 32'd0);
        gap_pulse();
        check("lock5", 32'(locked_o), 32'd1);
        check("lock_period", 32'(period_o), 32'd129);
        check("lock_err", 32'(err_count_o), 32'd0);
        check("lock_flags", 32'(miss_seen + early_seen), 32'd0);

        // Dropped pulse while locked
        repeat (128) cyc(1'b1, 1'b0);
        check("pre_miss", 32'(miss_seen), 32'd0);
        cyc(1'b1, 1'b0);
        check("miss_flag", 32'(miss_o), 32'd1);
        check("miss_unlock", 32'(locked_o), 32'd0);
        check("miss_err", 32'(err_count_o), exp_err(1));
        cyc(1'b1, 1'b0);
        check("miss_width", 32'(miss_o), 32'd0);
        repeat (200) cyc(1'b1, 1'b0);
        check("miss_once", 32'(miss_seen), 32'd1);
        cyc(1'b1, 1'b1);
        repeat (3) gap_pulse();
        check("relock_pre", 32'(locked_o), 32'd0);
        gap_pulse();
        check("relock", 32'(locked_o), 32'd1);

        // Early pulse 100 cycles after a good pulse
        repeat (99) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("early_flag", 32'(early_o), 32'd1);
        check("early_period", 32'(period_o), 32'd100);
        check("early_unlock", 32'(locked_o), 32'd0);
        check("early_err", 32'(err_count_o), exp_err(2));
        cyc(1'b1, 1'b0);
        check("early_width", 32'(early_o), 32'd0);
        repeat (127) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (2) gap_pulse();
        check("early_relock_pre", 32'(locked_o), 32'd0);
        gap_pulse();
        check("early_relock", 32'(locked_o), 32'd1);

        // Sparse enable
        do_reset();
        repeat (4) sparse_period(1'b1);
        check("sparse_pre", 32'(locked_o), 32'd0);
        cyc(1'b1, 1'b1);
        check("sparse_lock", 32'(locked_o), 32'd1);
        check("sparse_period", 32'(period_o), 32'd129);
        for (int k = 1; k < 387; k++) cyc((k % 3) == 0, k < 3);
        check("sparse_hold", 32'(locked_o), 32'd1);
        check("sparse_flags", 32'(miss_seen + early_seen), 32'd0);

        // Error saturation
        do_reset();
        cyc(1'b1, 1'b1);
        repeat (260) cyc(1'b1, 1'b1);
        check("sat_early_cnt", 32'(early_seen), 32'd260);
        check("sat_err", 32'(err_count_o), exp_err(255));
        clear_err_i = 1'b1;
        cyc(1'b1, 1'b1);
        check("clr_with_err", 32'(err_count_o), exp_err(1));
        cyc(1'b1, 1'b0);
        check("clr_alone", 32'(err_count_o), 32'd0);
        clear_err_i = 1'b0;

        // Reset mid-LOCKED
        do_reset();
        cyc(1'b1, 1'b1);
        repeat (4) gap_pulse();
        check("mid_locked", 32'(locked_o), 32'd1);
        repeat (50) cyc(1'b1, 1'b0);
        reset_i = 1'b1;
        cyc(1'b1, 1'b0);
        reset_i = 1'b0;
        check("mid_rst_locked", 32'(locked_o), 32'd0);
        check("mid_rst_period", 32'(period_o), 32'd0);
        check("mid_rst_flags", 32'(miss_o | early_o), 32'd0);
        check("mid_rst_err", 32'(err_count_o), 32'd0);
        miss_seen = 0;
        repeat (200) cyc(1'b1, 1'b0);
        check("mid_no_miss", 32'(miss_seen), 32'd0);
        cyc(1'b1, 1'b1);
        check("mid_search_period", 32'(period_o), 32'd0);
        gap_pulse();
        check("mid_track_period", 32'(period_o), 32'd129);
        check("mid_track_unlocked", 32'(locked_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_period_checker.md
# pulse_period_checker

Receive-side companion to the enable-driven tick counter. It watches a periodic one-ce-wide pulse stream, measures the spacing between pulses in clock-enable units, and reports lock, missing pulses and early pulses. It sits at the consumer end of any tick line produced by the counter block and flags a broken or mis-configured tick source.

## Interface
- PERIOD, 129: expected spacing between pulses, in ce-qualified cycles; legal range 2 to 2^CNT_W-1.
- LOCK_COUNT, 4: consecutive good intervals required to declare lock; range 1 to 15.
- CNT_W, 8: width of the interval counter and of period_o.
- clk_i  in  1  sole clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ce_i  in  1  clock enable; pulse_i is sampled only when ce_i=1.
- pulse_i  in  1  tick input; level may be held across non-ce cycles.
- clear_err_i  in  1  synchronous clear of err_count_o.
- locked_o  out  1  high while in LOCKED.
- miss_o  out  1  one-cycle flag: expected pulse absent.
- early_o  out  1  one-cycle flag: pulse arrived before PERIOD.
- period_o  out  CNT_W  last measured interval, saturating.
- err_count_o  out  8  saturating count of miss and early events.

## Operation
- Event: ce_i && pulse_i. A pulse held over several non-ce cycles counts once per ce cycle.
- Interval counter cnt:
  - Set to 0 on an event.
  - Otherwise incremented on each ce_i cycle, saturating at 2^CNT_W-1.
  - Measured interval m = cnt+1, saturating at 2^CNT_W-1.
- FSM states:
  - SEARCH (reset state): no reference pulse yet. An event moves to TRACK with good=0. No miss or early flags are raised in SEARCH.
  - TRACK, on an event:
    - m==PERIOD: good increments. When good reaches LOCK_COUNT, move to LOCKED.
    - m<PERIOD: assert early_o, err increments, good=0, stay in TRACK.
  - LOCKED, on an event: m==PERIOD keeps the state; m<PERIOD asserts early_o, err increments, and the state moves to TRACK with good=0.
  - TRACK or LOCKED, ce cycle with no event and m==PERIOD: assert miss_o, err increments, move to SEARCH. Only one miss is reported per gap.
- period_o is updated to m on every event taken in TRACK or LOCKED. It is not updated on the first event taken in SEARCH.
- err_count_o saturates at 255. clear_err_i together with an error in the same cycle gives err_count_o=1. clear_err_i alone gives 0.
- Reset: state SEARCH, cnt=0, good=0. Every output reads 0 the cycle after reset_i is sampled high, including mid-operation.

## Timing
- All outputs are registered. Each flag appears on the cycle after the ce cycle that caused it.
- miss_o and early_o are exactly one clk_i cycle wide, whatever the ce_i duty.
- locked_o rises one cycle after the LOCK_COUNT-th good event. It falls one cycle after a miss or early event.
- With ce_i constantly high, source pulses 129 cycles apart and defaults, locked_o rises 1 cycle after the 5th pulse.

## Configuration
- PULSE_CHECK_ERRCNT_EN defined: the err_count_o counter and clear_err_i logic are built.
- PULSE_CHECK_ERRCNT_EN undefined:
  - err_count_o is tied to 8'h00 and clear_err_i is ignored.
  - miss_o, early_o, locked_o and period_o are unchanged.

## Structure
- Shared package/header holds:
  - the state encoding (SEARCH=2'd0, TRACK=2'd1, LOCKED=2'd2);
  - defaults PERIOD=129, LOCK_COUNT=4, CNT_W=8;
  - the err counter width of 8.
- Sub-module interval_counter holds cnt and its saturation logic.
  - Inputs: clk_i, reset_i, ce_i, restart.
  - Output: saturated m.
- The FSM, good counter, flags and error counter live in the top level.

## Test plan
- Lock from reset (defaults): ce_i=1, pulse_i high 1 cycle every 129 cycles.
  - locked_o rises 1 cycle after the 5th pulse.
  - period_o=129, err_count_o=0.
- Dropped pulse while locked:
  - miss_o is high for 1 cycle, 130 cycles after the last pulse.
  - locked_o=0 and err_count_o=1.
  - The next 5 pulses relock.
- Early pulse 100 cycles after a good pulse:
  - early_o is high for 1 cycle and period_o=100.
  - err_count_o increments and locked_o=0.
  - Relock needs 4 more good intervals.
- Sparse enable: ce_i every 3rd cycle, pulse_i held high for 3 cycles every 387 cycles.
  - Exactly one event per pulse.
  - Locks with period_o=129 and raises no flags.
- Error saturation (macro on): force 260 early events, then assert clear_err_i in the same cycle as an error.
  - err_count_o holds at 255, then reads 1.
  - With the macro off, err_count_o stays 0 throughout.
- Reset mid-LOCKED: pulse reset_i for 1 cycle.
  - All outputs read 0 the next cycle.
  - No miss_o is raised at the next expected pulse time.
  - The first following pulse enters TRACK.
